// File: rtl/rdctl_pkg.sv
// Shared constants and types for the package reader (and the package writer).
package rdctl_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int PAIR_W = 32;
  localparam int LEN_W  = 10;

  // Package layout shared with the writer: six header words (h0..h5) fill
  // the first three pairs, the footer occupies the final pair.
  localparam int HEADER_COUNT        = 6;
  localparam int HEADER_PAIRS        = HEADER_COUNT / 2;
  localparam int FOOTER_WORDS        = 2;
  localparam int FOOTER_PAIR_FROM_END = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // True when the package would run past the end of the RAM. Widened to
  // 15 bits so the sum cannot wrap.
  function automatic logic range_bad(input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len,
                                     input logic [ADDR_W-1:0] depth);
    logic [ADDR_W:0] end_addr;
    end_addr = {1'b0, addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
    return end_addr > {1'b0, depth};
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO holding {odd, even} word pairs returned by the RAMs.
// Head entry is visible on dout whenever the FIFO is not empty.
module pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Pointer increment that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a push into a full FIFO is allowed only
  // when the head is popped in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/read_control.sv
// Package reader: issues paired reads to the even/odd RAMs under a credit
// limit, buffers the returned pairs and serializes them as a 16-bit stream.
//
// Output handshake: a word transfers on a rising clk edge where out_valid
// and out_ready are both high. Once out_valid is high, out_data, out_valid
// and out_last hold until that transfer happens; out_valid never depends
// combinationally on out_ready.
module read_control
  import rdctl_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  HALF_PACKAGE_LENGTH,
  input  logic [ADDR_W-1:0] MEMORY_DEPTH,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] even_q,
  input  logic [DATA_W-1:0] odd_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output state_t            dbg_state
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = $clog2(FIFO_DEPTH + RAM_LATENCY + 2) + 1;

  state_t                 state_q, state_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]       iss_cnt_q, iss_cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       pop_cnt_q, pop_cnt_d;
  logic                   half_sel_q, half_sel_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   addr_err_q, addr_err_d;
  logic [RAM_LATENCY-1:0] vld_sr_q, vld_sr_d;

  logic [PAIR_W-1:0]      head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   push;
  logic                   pop;
  logic                   word_hs;
  logic                   head_final;
  logic                   last_hs;
  logic [CRW-1:0]         committed;
  logic                   credit_ok;

  pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({odd_q, even_q}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Reads in flight: the read issued this cycle plus the latency pipeline.
  // The oldest pipeline stage is the one whose data is on even_q/odd_q now.
  assign push = vld_sr_q[RAM_LATENCY-1];

  // Serializer: even half first, the pair pops when the odd half transfers.
  assign out_valid  = ~fifo_empty;
  assign out_data   = out_valid ? (half_sel_q ? head[PAIR_W-1:DATA_W] : head[DATA_W-1:0])
                                : '0;
  assign head_final = (pop_cnt_q == len_q - LEN_W'(1));
  assign out_last   = out_valid & half_sel_q & head_final;
  assign word_hs    = out_valid & out_ready;
  assign pop        = word_hs & half_sel_q;
  assign last_hs    = word_hs & out_last;

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign dbg_state = state_q;

  // Credit check: buffered pairs plus reads still in the RAM pipeline, minus
  // the pair leaving this cycle, must leave room for one more read.
  always_comb begin
    committed = CRW'(fifo_count) + CRW'(rd_en_q);
    for (int i = 0; i < RAM_LATENCY; i++) begin
      committed = committed + CRW'(vld_sr_q[i]);
    end
    committed = committed - CRW'(pop);
    credit_ok = (committed < CRW'(FIFO_DEPTH)) & (~fifo_full | pop);
  end

  // Next-state logic for the sequencer, serializer position and status.
  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    iss_cnt_d  = iss_cnt_q;
    len_d      = len_q;
    pop_cnt_d  = pop_cnt_q;
    half_sel_d = half_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    addr_err_d = addr_err_q;
    vld_sr_d   = RAM_LATENCY'({vld_sr_q, rd_en_q});

    if (word_hs) begin
      half_sel_d = ~half_sel_q;
    end
    if (pop) begin
      pop_cnt_d = pop_cnt_q + LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_err_d = 1'b0;
          len_d      = HALF_PACKAGE_LENGTH;
          pop_cnt_d  = '0;
          half_sel_d = 1'b0;
          if (range_bad(start_addr, HALF_PACKAGE_LENGTH, MEMORY_DEPTH)) begin
            addr_err_d = 1'b1;
            done_d     = 1'b1;
          end else if (HALF_PACKAGE_LENGTH == '0) begin
            done_d = 1'b1;
          end else begin
            // First read goes out the cycle after the start is accepted;
            // the FIFO is empty here so no credit check is needed.
            rd_en_d   = 1'b1;
            rd_addr_d = start_addr;
            iss_cnt_d = LEN_W'(1);
            busy_d    = 1'b1;
            state_d   = (HALF_PACKAGE_LENGTH == LEN_W'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          iss_cnt_d = iss_cnt_q + LEN_W'(1);
          if (iss_cnt_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The final pair being at the head implies everything earlier has
        // already been pushed and popped.
        if (last_hs) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and status registers; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      iss_cnt_q  <= '0;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      half_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      vld_sr_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      iss_cnt_q  <= iss_cnt_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      half_sel_q <= half_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      vld_sr_q   <= vld_sr_d;
    end
  end

endmodule

// File: tb/tb_read_control.sv
// Directed bench for read_control with a latency-2 RAM model and a word
// scoreboard fed from a negedge monitor.
module tb_read_control;
  import rdctl_pkg::*;

  localparam int L  = 2;
  localparam int FD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [9:0]  half = '0;
  logic [13:0] mem_depth = 14'h3FFF;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [15:0] even_q, odd_q;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last, busy, done, addr_err;
  state_t      dbg_state;

  initial out_ready = 1'b1;

  read_control #(.RAM_LATENCY(L), .FIFO_DEPTH(FD)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .start_addr          (start_addr),
    .HALF_PACKAGE_LENGTH (half),
    .MEMORY_DEPTH        (mem_depth),
    .rd_en               (rd_en),
    .rd_addr             (rd_addr),
    .even_q              (even_q),
    .odd_q               (odd_q),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_last            (out_last),
    .busy                (busy),
    .done                (done),
    .addr_err            (addr_err),
    .dbg_state           (dbg_state)
  );

  // ---------------- RAM model: pattern {odd=0x8000|a, even=a} ----------------
  logic [13:0]  ram_a [L];
  logic [L-1:0] ram_v = '0;
  always @(posedge clk) begin
    ram_a[0] <= rd_addr;
    ram_v[0] <= rd_en;
    for (int i = 1; i < L; i++) begin
      ram_a[i] <= ram_a[i-1];
      ram_v[i] <= ram_v[i-1];
    end
  end
  assign even_q = ram_v[L-1] ? {2'b00, ram_a[L-1]} : 16'hBAD0;
  assign odd_q  = ram_v[L-1] ? (16'h8000 | {2'b00, ram_a[L-1]}) : 16'hBAD1;

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int errors = 0;
  int checks = 0;
  int start_cyc = 0;
  int first_rel, last_rel, last_idx, done_cnt, done_rel, rd_cnt;
  int valid_cnt, stall_err, max_out, busy_rel;
  bit prev_stall;
  logic [15:0] prev_data;

  task automatic clear_mon();
    got_q.delete();
    first_rel = -1; last_rel = -1; last_idx = -1; done_cnt = 0; done_rel = -1;
    rd_cnt = 0; valid_cnt = 0; stall_err = 0; max_out = 0; busy_rel = -1;
    prev_stall = 1'b0; prev_data = '0;
  endtask

  always @(negedge clk) begin
    if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid) valid_cnt++;
    if (rd_en) rd_cnt++;
    if (busy && busy_rel < 0) busy_rel = cyc - start_cyc;
    if (done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (got_q.size() == 1) first_rel = cyc - start_cyc;
      if (out_last) begin
        last_rel = cyc - start_cyc;
        last_idx = got_q.size();
      end
    end
    if (rd_cnt - (got_q.size() / 2) > max_out) max_out = rd_cnt - (got_q.size() / 2);
  end

  // ---------------- driver tasks ----------------
  task automatic build_exp(input logic [13:0] a, input int h);
    exp_q.delete();
    for (int i = 0; i < h; i++) begin
      exp_q.push_back({2'b00, a + 14'(i)});
      exp_q.push_back(16'h8000 | {2'b00, a + 14'(i)});
    end
  endtask

  task automatic do_start(input logic [13:0] a, input logic [9:0] h, input logic [13:0] d);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; half = h; mem_depth = d;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start(input logic [13:0] a, input logic [9:0] h);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; half = h;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_words(input string name);
    int bad;
    int idx;
    bad = 0; idx = -1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (idx < 0) idx = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_data: %0d bad words, first at %0d got %h expected %h",
               name, bad, idx, got_q[idx], exp_q[idx]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({rd_en, rd_addr, out_data, out_valid, out_last, busy, done, addr_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_en=%b rd_addr=%h out_data=%h valid=%b last=%b busy=%b done=%b err=%b expected all 0",
               rd_en, rd_addr, out_data, out_valid, out_last, busy, done, addr_err);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected IDLE", dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stream(input string name);
    out_ready = 1'b1;
    build_exp(14'h0100, 516);
    do_start(14'h0100, 10'd516, 14'h3FFF);
    wait_done(3000, 1'b0, name);
    check_words(name);
    checks++;
    if (busy_rel !== 1) begin errors++; $display("FAIL %s_busy: busy first at cycle %0d expected 1", name, busy_rel); end
    checks++;
    if (first_rel !== 4) begin errors++; $display("FAIL %s_first: first word at cycle %0d expected 4", name, first_rel); end
    checks++;
    if (last_rel !== 1035 || last_idx !== 1032) begin
      errors++;
      $display("FAIL %s_last: out_last at cycle %0d word %0d expected cycle 1035 word 1032", name, last_rel, last_idx);
    end
    checks++;
    if (done_rel !== 1036 || done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done: done at cycle %0d count %0d expected cycle 1036 count 1", name, done_rel, done_cnt);
    end
    checks++;
    if (rd_cnt !== 516) begin errors++; $display("FAIL %s_reads: %0d reads expected 516", name, rd_cnt); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL %s_idle: busy=%b state=%0d expected busy=0 IDLE", name, busy, dbg_state);
    end
  endtask

  task automatic test_backpressure();
    build_exp(14'h0100, 516);
    do_start(14'h0100, 10'd516, 14'h3FFF);
    wait_done(8000, 1'b1, "bp");
    check_words("bp");
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: %0d stall changes expected 0", stall_err); end
    checks++;
    if (max_out > FD) begin errors++; $display("FAIL bp_credit: %0d outstanding pairs expected at most %0d", max_out, FD); end
    checks++;
    if (last_idx !== 1032 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_end: last word %0d done count %0d expected 1032 and 1", last_idx, done_cnt);
    end
  endtask

  task automatic test_addr_err();
    do_start(14'h3E00, 10'd516, 14'h3FFF);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL err_flag: addr_err=%b expected 1", addr_err); end
    checks++;
    if (done_rel !== 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL err_done: done at cycle %0d count %0d expected cycle 1 count 1", done_rel, done_cnt);
    end
    checks++;
    if (rd_cnt !== 0 || busy_rel !== -1) begin
      errors++;
      $display("FAIL err_noread: reads %0d busy at %0d expected 0 reads and no busy", rd_cnt, busy_rel);
    end
  endtask

  task automatic test_zero_len();
    do_start(14'h0010, 10'd0, 14'h3FFF);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_rel !== 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL zero_done: done at cycle %0d count %0d expected cycle 1 count 1", done_rel, done_cnt);
    end
    checks++;
    if (valid_cnt !== 0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL zero_quiet: valid cycles %0d reads %0d expected 0 and 0", valid_cnt, rd_cnt);
    end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL zero_errclr: addr_err=%b expected 0", addr_err); end
  endtask

  task automatic test_start_ignored();
    build_exp(14'h0020, 8);
    do_start(14'h0020, 10'd8, 14'h3FFF);
    repeat (3) @(posedge clk);
    pulse_start(14'h0040, 10'd3);
    wait_done(200, 1'b0, "busy_start");
    repeat (20) @(posedge clk);
    #1;
    check_words("busy_start");
    checks++;
    if (done_cnt !== 1 || rd_cnt !== 8) begin
      errors++;
      $display("FAIL busy_start_once: done count %0d reads %0d expected 1 and 8", done_cnt, rd_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n;
    out_ready = 1'b1;
    do_start(14'h0100, 10'd516, 14'h3FFF);
    n = 0;
    while (got_q.size() < 100 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (got_q.size() < 100) begin errors++; $display("FAIL rst_wait: %0d words expected 100", got_q.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, rd_addr, out_data, out_valid, out_last, busy, done, addr_err} !== '0) begin
      errors++;
      $display("FAIL rst_clear: rd_en=%b rd_addr=%h out_data=%h valid=%b last=%b busy=%b done=%b expected all 0",
               rd_en, rd_addr, out_data, out_valid, out_last, busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rst_nodone: done count %0d state %0d expected 0 and IDLE", done_cnt, dbg_state);
    end
    test_stream("restart");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_mon();
    test_reset();
    test_stream("stream");
    test_backpressure();
    test_addr_err();
    test_zero_len();
    test_start_ignored();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
